mem_arbiter: RTL and testbench

- Sequences and shares the single-port word RAM (30-bit word address, 32-bit data, 4 byte strobes, read/write) between two requesters: port 0 (CPU data access) and port 1 (instruction fetch / DMA).
- Round-robin arbitration, valid/ready request handshake, one-cycle response pulse.
- Drives the RAM control signals from registers on the rising edge. The RAM acts on the falling edge, so read data is stable at the next rising edge.

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request, response and RAM-side signals of mem_arbiter (MEM_ARB_LOCK_EN adds req0_lock)
interface mem_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [29:0] req0_address;
    logic [31:0] req0_data;
    logic [3:0]  req0_strobes;
    logic        req0_write;
`ifdef MEM_ARB_LOCK_EN
    logic        req0_lock;
`endif
    logic        resp0_valid;
    logic [31:0] resp0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [29:0] req1_address;
    logic [31:0] req1_data;
    logic [3:0]  req1_strobes;
    logic        req1_write;
    logic        resp1_valid;
    logic [31:0] resp1_data;
    logic [29:0] mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_strobes;
    logic        mem_read;
    logic        mem_write;

    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  req0_lock,
`endif
        input  req0_valid, req0_address, req0_data, req0_strobes, req0_write,
        output req0_ready, resp0_valid, resp0_data,
        input  req1_valid, req1_address, req1_data, req1_strobes, req1_write,
        output req1_ready, resp1_valid, resp1_data,
        output mem_address, mem_data_out, mem_strobes, mem_read, mem_write,
        input  mem_data_in
    );

    modport master (
`ifdef MEM_ARB_LOCK_EN
        output req0_lock,
`endif
        output req0_valid, req0_address, req0_data, req0_strobes, req0_write,
        input  req0_ready, resp0_valid, resp0_data,
        output req1_valid, req1_address, req1_data, req1_strobes, req1_write,
        input  req1_ready, resp1_valid, resp1_data,
        input  mem_address, mem_data_out, mem_strobes, mem_read, mem_write,
        output mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter for a single-port word RAM (optional MEM_ARB_LOCK_EN)
module mem_arbiter #(
    parameter int WAIT_STATES = 0
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        prio_q, prio_d;
    logic [3:0]  wait_q, wait_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic [3:0]  stb_q, stb_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        rv0_q, rv0_d, rv1_q, rv1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        ready0, ready1, sel, sel_write, lock_hold;

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.resp0_valid  = rv0_q;
    assign bus.resp1_valid  = rv1_q;
    assign bus.resp0_data   = rdata0_q;
    assign bus.resp1_data   = rdata1_q;
    assign bus.mem_address  = addr_q;
    assign bus.mem_data_out = dout_q;
    assign bus.mem_strobes  = stb_q;
    assign bus.mem_read     = rd_q;
    assign bus.mem_write    = wr_q;

`ifdef MEM_ARB_LOCK_EN
    assign lock_hold = bus.req0_lock;
`else
    assign lock_hold = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            wait_q   <= 4'd0;
            addr_q   <= 30'd0;
            dout_q   <= 32'd0;
            stb_q    <= 4'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            stb_q    <= stb_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        stb_d     = stb_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        rv0_d     = 1'b0;
        rv1_d     = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        // A port wins alone, or on a tie when the pointer names it.
        ready0    = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || !prio_q);
        ready1    = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || prio_q);
        sel       = ready1;
        sel_write = sel ? bus.req1_write : bus.req0_write;

        case (state_q)
            IDLE: begin
                if (ready0 || ready1) begin
                    addr_d  = sel ? bus.req1_address : bus.req0_address;
                    dout_d  = sel ? bus.req1_data    : bus.req0_data;
                    stb_d   = sel ? bus.req1_strobes : bus.req0_strobes;
                    rd_d    = !sel_write;
                    wr_d    = sel_write;
                    owner_d = sel;
                    wait_d  = 4'(WAIT_STATES);
                    prio_d  = (!sel && lock_hold) ? 1'b0 : !sel;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = IDLE;
                    if (owner_q) begin
                        rv1_d = 1'b1;
                        if (rd_q) rdata1_d = bus.mem_data_in;
                    end else begin
                        rv0_d = 1'b1;
                        if (rd_q) rdata0_d = bus.mem_data_in;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed checks of mem_arbiter at WAIT_STATES 0 and 3
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        v0 [2], v1 [2], w0 [2], w1 [2], lk [2];
    logic [29:0] a0 [2], a1 [2];
    logic [31:0] d0 [2], d1 [2];
    logic [3:0]  s0 [2], s1 [2];
    logic [31:0] mdin [2];

    wire         r0 [2], r1 [2], rv0 [2], rv1 [2], mrd [2], mwr [2];
    wire  [31:0] rd0 [2], rd1 [2], mdout [2];
    wire  [29:0] maddr [2];
    wire  [3:0]  mstb [2];

    for (genvar g = 0; g < 2; g++) begin : gd
        mem_arbiter_if bus ();
        mem_arbiter #(.WAIT_STATES(g * 3)) dut (.clock(clk), .reset(rst), .bus(bus.slave));
        assign bus.req0_valid   = v0[g];
        assign bus.req0_address = a0[g];
        assign bus.req0_data    = d0[g];
        assign bus.req0_strobes = s0[g];
        assign bus.req0_write   = w0[g];
        assign bus.req1_valid   = v1[g];
        assign bus.req1_address = a1[g];
        assign bus.req1_data    = d1[g];
        assign bus.req1_strobes = s1[g];
        assign bus.req1_write   = w1[g];
        assign bus.mem_data_in  = mdin[g];
`ifdef MEM_ARB_LOCK_EN
        assign bus.req0_lock    = lk[g];
`endif
        assign r0[g]    = bus.req0_ready;
        assign r1[g]    = bus.req1_ready;
        assign rv0[g]   = bus.resp0_valid;
        assign rv1[g]   = bus.resp1_valid;
        assign rd0[g]   = bus.resp0_data;
        assign rd1[g]   = bus.resp1_data;
        assign maddr[g] = bus.mem_address;
        assign mdout[g] = bus.mem_data_out;
        assign mstb[g]  = bus.mem_strobes;
        assign mrd[g]   = bus.mem_read;
        assign mwr[g]   = bus.mem_write;
    end

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h01010101) ^ 32'hA5C3_5A3C;
    endfunction

    // RAM: acts on the falling edge, 64 words aliased on address[5:0].
    logic [31:0] ram [2][64];
    bit ram_loaded = 1'b0;
    always @(negedge clk) begin
        if (!ram_loaded) begin
            for (int g = 0; g < 2; g++)
                for (int i = 0; i < 64; i++) ram[g][i] = init_val(i);
            ram_loaded = 1'b1;
        end
        for (int g = 0; g < 2; g++) begin
            if (mrd[g] === 1'b1) mdin[g] <= ram[g][maddr[g][5:0]];
            if (mwr[g] === 1'b1)
                for (int b = 0; b < 4; b++)
                    if (mstb[g][b]) ram[g][maddr[g][5:0]][8*b +: 8] <= mdout[g][8*b +: 8];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction-level view with a countdown to the response.
    logic [31:0] ref_mem [2][64];
    bit          m_busy [2], m_wr [2], m_prio [2];
    int          m_rem [2], m_owner [2];
    logic [29:0] m_addr [2];
    logic [31:0] m_dout [2], m_rdata [2];
    logic [3:0]  m_stb [2];
    logic [31:0] m_last [2][2];
    int          grant_log [$];

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            m_busy[g] = 0; m_prio[g] = 0; m_rem[g] = 0;
            m_last[g][0] = 32'd0; m_last[g][1] = 32'd0;
        end
        grant_log.delete();
    endtask

    task automatic set_idle();
        for (int g = 0; g < 2; g++) begin
            v0[g] = 0; v1[g] = 0; w0[g] = 0; w1[g] = 0; lk[g] = 0;
            a0[g] = '0; a1[g] = '0; d0[g] = '0; d1[g] = '0; s0[g] = '0; s1[g] = '0;
        end
    endtask

    task automatic step();
        bit acc0 [2], acc1 [2];
        int resp, p;
        #1;
        for (int g = 0; g < 2; g++) begin
            acc0[g] = !m_busy[g] && v0[g] && (!v1[g] || !m_prio[g]);
            acc1[g] = !m_busy[g] && v1[g] && (!v0[g] || m_prio[g]);
            check_eq($sformatf("ready0[%0d]", g), 32'(r0[g]), 32'(acc0[g]));
            check_eq($sformatf("ready1[%0d]", g), 32'(r1[g]), 32'(acc1[g]));
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            resp = -1;
            if (m_busy[g]) begin
                m_rem[g]--;
                if (m_rem[g] == 0) begin
                    resp = m_owner[g];
                    m_busy[g] = 0;
                    if (!m_wr[g]) m_last[g][m_owner[g]] = m_rdata[g];
                end
            end else if (acc0[g] || acc1[g]) begin
                p = acc1[g] ? 1 : 0;
                m_busy[g]  = 1;
                m_rem[g]   = g * 3 + 1;
                m_owner[g] = p;
                m_wr[g]    = p ? w1[g] : w0[g];
                m_addr[g]  = p ? a1[g] : a0[g];
                m_dout[g]  = p ? d1[g] : d0[g];
                m_stb[g]   = p ? s1[g] : s0[g];
                if (m_wr[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (m_stb[g][b]) ref_mem[g][m_addr[g][5:0]][8*b +: 8] = m_dout[g][8*b +: 8];
                end else begin
                    m_rdata[g] = ref_mem[g][m_addr[g][5:0]];
                end
                m_prio[g] = (p == 0) ? 1'b1 : 1'b0;
`ifdef MEM_ARB_LOCK_EN
                if (p == 0 && lk[g]) m_prio[g] = 1'b0;
`endif
                if (g == 0) grant_log.push_back(p);
            end
            check_eq($sformatf("resp0_valid[%0d]", g), 32'(rv0[g]), 32'(resp == 0));
            check_eq($sformatf("resp1_valid[%0d]", g), 32'(rv1[g]), 32'(resp == 1));
            check_eq($sformatf("resp0_data[%0d]", g), rd0[g], m_last[g][0]);
            check_eq($sformatf("resp1_data[%0d]", g), rd1[g], m_last[g][1]);
            check_eq($sformatf("mem_read[%0d]", g), 32'(mrd[g]), 32'(m_busy[g] && !m_wr[g]));
            check_eq($sformatf("mem_write[%0d]", g), 32'(mwr[g]), 32'(m_busy[g] && m_wr[g]));
            if (m_busy[g]) begin
                check_eq($sformatf("mem_address[%0d]", g), 32'(maddr[g]), 32'(m_addr[g]));
                check_eq($sformatf("mem_data_out[%0d]", g), mdout[g], m_dout[g]);
                check_eq($sformatf("mem_strobes[%0d]", g), 32'(mstb[g]), 32'(m_stb[g]));
            end
        end
    endtask

    task automatic drain(input int n);
        set_idle();
        repeat (n) step();
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        logic [31:0] exp_word;
        rst = 1'b1;
        set_idle();
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 64; i++) ref_mem[g][i] = init_val(i);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check_eq("rst_mem_read", 32'(mrd[g]), 32'd0);
            check_eq("rst_mem_write", 32'(mwr[g]), 32'd0);
            check_eq("rst_mem_address", 32'(maddr[g]), 32'd0);
            check_eq("rst_mem_data_out", mdout[g], 32'd0);
            check_eq("rst_mem_strobes", 32'(mstb[g]), 32'd0);
            check_eq("rst_resp0", {rd0[g][30:0], rv0[g]}, 32'd0);
            check_eq("rst_resp1", {rd1[g][30:0], rv1[g]}, 32'd0);
        end
        rst = 1'b0;

        // Contention from reset: strict alternation starting with port 0.
        for (int g = 0; g < 2; g++) begin
            v0[g] = 1; v1[g] = 1; a0[g] = 30'd1; a1[g] = 30'd2;
        end
        repeat (8) step();
        check_eq("contend_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < grant_log.size() && i < 4; i++)
            check_eq($sformatf("contend_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
        drain(8);

        // Single read of 0x10 after loading it through port 1.
        for (int g = 0; g < 2; g++) begin
            v1[g] = 1; w1[g] = 1; a1[g] = 30'h10; d1[g] = 32'hDEADBEEF; s1[g] = 4'hF;
        end
        step();
        drain(6);
        for (int g = 0; g < 2; g++) begin
            v0[g] = 1; w0[g] = 0; a0[g] = 30'h10;
        end
        step();
        set_idle();
        check_eq("single_read_mem_read", 32'(mrd[0]), 32'd1);
        step();
        check_eq("single_read_resp0_valid", 32'(rv0[0]), 32'd1);
        check_eq("single_read_resp1_valid", 32'(rv1[0]), 32'd0);
        check_eq("single_read_data", rd0[0], 32'hDEADBEEF);
        drain(6);

        // Byte-strobed write then read-back on 0x20.
        for (int g = 0; g < 2; g++) begin
            v1[g] = 1; w1[g] = 1; a1[g] = 30'h20; d1[g] = 32'h11223344; s1[g] = 4'b0010;
        end
        step();
        drain(6);
        for (int g = 0; g < 2; g++) begin
            v0[g] = 1; w0[g] = 0; a0[g] = 30'h20;
        end
        step();
        drain(6);
        exp_word = init_val(32);
        exp_word[15:8] = 8'h33;
        check_eq("strobe_write_ws0", rd0[0], exp_word);
        check_eq("strobe_write_ws3", rd0[1], exp_word);

        // Latency with three wait states.
        for (int g = 0; g < 2; g++) begin
            v0[g] = 1; w0[g] = 0; a0[g] = 30'h7;
        end
        step();
        set_idle();
        k = 0;
        while (rv0[1] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check_eq("ws3_latency", 32'(k), 32'd4);
        drain(6);

        // Reset during BUSY abandons the access.
        for (int g = 0; g < 2; g++) begin
            v0[g] = 1; w0[g] = 0; a0[g] = 30'h3;
        end
        step();
        set_idle();
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            check_eq("midrst_mem_read", 32'(mrd[g]), 32'd0);
            check_eq("midrst_mem_write", 32'(mwr[g]), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check_eq("midrst_resp0", 32'(rv0[g]), 32'd0);
            check_eq("midrst_resp1", 32'(rv1[g]), 32'd0);
        end
        model_reset();
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            v0[g] = 1; v1[g] = 1;
        end
        step();
        check_eq("midrst_tie_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 32'd0);
        drain(6);

`ifdef MEM_ARB_LOCK_EN
        do_reset();
        for (int g = 0; g < 2; g++) begin
            v0[g] = 1; v1[g] = 1; lk[g] = 1;
        end
        repeat (4) step();
        for (int g = 0; g < 2; g++) lk[g] = 0;
        repeat (4) step();
        check_eq("lock_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            check_eq("lock_held", 32'(grant_log[1]), 32'd0);
            check_eq("lock_released", 32'(grant_log[3]), 32'd1);
        end
        drain(6);
`endif

        // Randomized traffic on both instances.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int g = 0; g < 2; g++) begin
                v0[g] = ($urandom_range(0, 9) < 6);
                v1[g] = ($urandom_range(0, 9) < 6);
                w0[g] = $urandom_range(0, 1);
                w1[g] = $urandom_range(0, 1);
                a0[g] = 30'($urandom);
                a1[g] = 30'($urandom);
                d0[g] = $urandom;
                d1[g] = $urandom;
                s0[g] = 4'($urandom);
                s1[g] = 4'($urandom);
                lk[g] = $urandom_range(0, 1);
            end
            step();
        end
        drain(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
